// File: rtl/ysyx_22051013_icache_axi_bridge.sv
// I-cache refill responder: one held-level fetch request -> one single-beat AXI4 read -> one-cycle data pulse.
// Optional macro YSYX_22051013_IBRIDGE_ERR_EN substitutes NOP words on RRESP errors and raises a sticky bus_err.
module ysyx_22051013_icache_axi_bridge #(
    parameter int          ADDR_W   = 32,
    parameter logic [3:0]  AXI_ID   = 4'd0,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ena,
    input  logic [63:0]       req_addr,
    output logic [63:0]       rsp_data,
    output logic              rsp_valid,
    output logic              busy,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [3:0]        ar_id,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [63:0]       r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_ena)  state_nxt = AR;
            AR:   if (ar_ready) state_nxt = R;
            R:    if (r_valid)  state_nxt = RESP;
            RESP:               state_nxt = IDLE;
        endcase
    end

    // The address is captured once on acceptance; later req_addr changes do not reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (state == IDLE && req_ena) begin
            addr_q <= {req_addr[ADDR_W-1:3], 3'b000};
        end
    end

`ifdef YSYX_22051013_IBRIDGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state == R && r_valid) begin
            if (r_resp != 2'b00) begin
                data_q <= {NOP_WORD, NOP_WORD};
                err_q  <= 1'b1;
            end else begin
                data_q <= r_data;
            end
        end
    end

    assign bus_err = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{r_last, req_addr[63:ADDR_W], req_addr[2:0]};
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        data_q <= '0;
        else if (state == R && r_valid) data_q <= r_data;
    end

    assign bus_err = 1'b0;

    // RRESP is ignored and RLAST is not needed: the single accepted beat ends the burst.
    logic unused_inputs;
    assign unused_inputs = ^{r_last, r_resp, NOP_WORD, req_addr[63:ADDR_W], req_addr[2:0]};
`endif

    assign busy      = (state != IDLE);
    assign ar_valid  = (state == AR);
    assign r_ready   = (state == R);
    assign rsp_valid = (state == RESP);
    assign ar_addr   = addr_q;
    assign rsp_data  = data_q;
    assign ar_id     = AXI_ID;
    assign ar_len    = 8'd0;
    assign ar_size   = 3'b011;
    assign ar_burst  = 2'b01;

endmodule

// File: tb/tb_ysyx_22051013_icache_axi_bridge.sv
// Self-checking bench for the icache AXI bridge: table-driven fetches, randomized slave timing, reset and error cases.
module tb_ysyx_22051013_icache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ena = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] rsp_data;
    logic        rsp_valid, busy, ar_valid, r_ready, bus_err;
    logic        ar_ready = 1'b0;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic        r_last = 1'b0;

    always #5 clk = ~clk;

    ysyx_22051013_icache_axi_bridge dut (
        .clk(clk), .rst(rst), .req_ena(req_ena), .req_addr(req_addr),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last), .bus_err(bus_err)
    );

`ifdef YSYX_22051013_IBRIDGE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    // One fetch: request, slave timing (AR wait cycles, R delay after entering R), expected results.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  resp;
        int          w_a;
        int          d_r;
        bit          drop;
        bit          spur;
        logic [31:0] exp_ar_addr;
        int          exp_rsp_cycle;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_rsp(input logic [63:0] d, input logic [1:0] resp);
        return (ERR_ON && resp != 2'b00) ? {2{32'h0000_0013}} : d;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " ar_valid"},  64'(ar_valid),  64'd0);
        check({tag, " r_ready"},   64'(r_ready),   64'd0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " bus_err"},   64'(bus_err),   64'(model_err));
    endtask

    task automatic idle_cycles(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
            req_ena  = 1'b0;
            ar_ready = spur;
            r_valid  = spur;
            r_data   = {$urandom, $urandom};
            r_resp   = 2'($urandom);
        end
    endtask

    // Cycle k follows edge k-1; the request is sampled at edge 0.
    task automatic run_txn(input txn_t t, input string tag);
        int          rc    = 2 + t.w_a + t.d_r;
        int          l     = t.exp_rsp_cycle;
        logic [63:0] exp_d = model_rsp(t.data, t.resp);
        for (int k = 0; k <= l; k++) begin
            @(negedge clk);
            if (k == l && ERR_ON && t.resp != 2'b00) model_err = 1'b1;
            check($sformatf("%s c%0d busy", tag, k),      64'(busy),      64'(k >= 1));
            check($sformatf("%s c%0d ar_valid", tag, k),  64'(ar_valid),  64'(k >= 1 && k <= 1 + t.w_a));
            check($sformatf("%s c%0d r_ready", tag, k),   64'(r_ready),   64'(k >= 2 + t.w_a && k < l));
            check($sformatf("%s c%0d rsp_valid", tag, k), 64'(rsp_valid), 64'(k == l));
            check($sformatf("%s c%0d bus_err", tag, k),   64'(bus_err),   64'(model_err));
            if (k >= 1 && k <= 1 + t.w_a) begin
                check($sformatf("%s c%0d ar_addr", tag, k),  64'(ar_addr),  64'(t.exp_ar_addr));
                check($sformatf("%s c%0d ar_id", tag, k),    64'(ar_id),    64'd0);
                check($sformatf("%s c%0d ar_len", tag, k),   64'(ar_len),   64'd0);
                check($sformatf("%s c%0d ar_size", tag, k),  64'(ar_size),  64'd3);
                check($sformatf("%s c%0d ar_burst", tag, k), 64'(ar_burst), 64'd1);
            end
            if (k == l) check($sformatf("%s rsp_data", tag), rsp_data, exp_d);
            req_ena  = (k == 0) || (!t.drop && k < l);
            req_addr = (k == 0) ? t.addr : {$urandom, $urandom};
            ar_ready = (k >= 1 + t.w_a) || (t.spur && k == 0);
            r_valid  = (k == rc) || (t.spur && k <= 1 + t.w_a);
            r_data   = (k == rc) ? t.data : {$urandom, $urandom};
            r_resp   = (k == rc) ? t.resp : 2'($urandom);
            r_last   = (k == rc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t tbl[7];
        txn_t t;

        tbl[0] = '{addr:64'h8000_0104, data:64'h0010_0093_0000_0413, resp:2'b00, w_a:0, d_r:1,
                   drop:0, spur:0, exp_ar_addr:32'h8000_0100, exp_rsp_cycle:4};
        tbl[1] = '{addr:64'h8000_1008, data:64'h1122_3344_5566_7788, resp:2'b00, w_a:3, d_r:5,
                   drop:0, spur:0, exp_ar_addr:32'h8000_1008, exp_rsp_cycle:11};
        tbl[2] = '{addr:64'h8000_0200, data:64'h0000_0513_0000_0593, resp:2'b00, w_a:0, d_r:1,
                   drop:0, spur:0, exp_ar_addr:32'h8000_0200, exp_rsp_cycle:4};
        tbl[3] = '{addr:64'h8000_0FFC, data:64'hCAFE_F00D_0BAD_BEEF, resp:2'b00, w_a:1, d_r:2,
                   drop:1, spur:0, exp_ar_addr:32'h8000_0FF8, exp_rsp_cycle:6};
        tbl[4] = '{addr:64'h1234_5678_9ABC_DEF7, data:64'h0123_4567_89AB_CDEF, resp:2'b00, w_a:2, d_r:0,
                   drop:0, spur:1, exp_ar_addr:32'h9ABC_DEF0, exp_rsp_cycle:5};
        tbl[5] = '{addr:64'h8000_0300, data:64'hDEAD_BEEF_DEAD_BEEF, resp:2'b10, w_a:0, d_r:1,
                   drop:0, spur:0, exp_ar_addr:32'h8000_0300, exp_rsp_cycle:4};
        tbl[6] = '{addr:64'h8000_0308, data:64'h0000_0297_0000_0317, resp:2'b00, w_a:1, d_r:1,
                   drop:0, spur:0, exp_ar_addr:32'h8000_0308, exp_rsp_cycle:5};

        @(negedge clk);
        check_idle("reset");
        check("reset ar_addr",  64'(ar_addr), 64'd0);
        check("reset rsp_data", rsp_data,     64'd0);
        rst = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));
        idle_cycles(2, 1'b1);

        for (int n = 0; n < 20; n++) begin
            t.addr          = {$urandom, $urandom};
            t.data          = {$urandom, $urandom};
            t.resp          = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t.w_a           = $urandom_range(0, 3);
            t.d_r           = $urandom_range(0, 4);
            t.drop          = 1'($urandom_range(0, 1));
            t.spur          = 1'($urandom_range(0, 1));
            t.exp_ar_addr   = 32'(t.addr) & 32'hFFFF_FFF8;
            t.exp_rsp_cycle = 3 + t.w_a + t.d_r;
            run_txn(t, $sformatf("rnd%0d", n));
            idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset asserted between edges while waiting in R: outputs must drop without a clock edge.
        @(negedge clk);
        check_idle("rst_seq pre");
        req_ena  = 1'b1;
        req_addr = 64'h8000_0400;
        ar_ready = 1'b1;
        r_valid  = 1'b0;
        @(negedge clk);
        check("rst_seq ar_valid", 64'(ar_valid), 64'd1);
        req_ena = 1'b0;
        @(negedge clk);
        check("rst_seq r_ready", 64'(r_ready), 64'd1);
        #2 rst = 1'b1;
        model_err = 1'b0;
        #1;
        check_idle("rst_seq async");
        check("rst_seq ar_addr",  64'(ar_addr), 64'd0);
        check("rst_seq rsp_data", rsp_data,     64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3, 1'b1);
        run_txn(tbl[0], "post_rst");
        idle_cycles(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
